ecp5pll_phase_ctrl: RTL and testbench

// - Sequencer for the ECP5 PLL dynamic-phase port: runs the PLL start-up reset, then turns phase requests
//   (output select, direction, step count) into timed phasesel/phasedir/phasestep/phaseloadreg waveforms.
// - Waits for re-lock after each request; reports done/err. Sits between SoC control logic and ecp5pll.

---
 rtl/ecp5pll_phase_ctrl_if.sv | 24 ++
 rtl/ecp5pll_phase_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ecp5pll_phase_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ecp5pll_phase_ctrl_if.sv
// Phase-request handshake between SoC control logic and the ECP5 PLL phase sequencer.
// master = requester, slave = sequencer.
interface ecp5pll_phase_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_sel;
   logic             req_dir;
   logic [CNT_W-1:0] req_steps;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output req_valid, req_sel, req_dir, req_steps,
      input  req_ready, busy, done, err
   );

   modport slave (
      input  req_valid, req_sel, req_dir, req_steps,
      output req_ready, busy, done, err
   );
endinterface

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequencer for ECP5 PLL start-up reset and dynamic phase steps; optional PHASE_TRACK_EN adds per-output phase counters.
// Latency: phasesel/phasedir one cycle after accept, then STEP_GAP setup, STEP_HOLD/STEP_GAP per step, then lock wait.
// Backpressure: req_ready only in IDLE while pll_locked; one request in flight at a time.
module ecp5pll_phase_ctrl #(
   parameter int RST_CYCLES   = 16,
   parameter int STEP_HOLD    = 4,
   parameter int STEP_GAP     = 4,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int CNT_W        = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_n,
   ecp5pll_phase_ctrl_if.slave  req,
   input  logic                 pll_locked,
   output logic                 pll_reset,
   output logic [1:0]           pll_phasesel,
   output logic                 pll_phasedir,
   output logic                 pll_phasestep,
   output logic                 pll_phaseloadreg
`ifdef PHASE_TRACK_EN
   ,
   output logic [63:0]          phase_pos_o
`endif
);

   localparam int MAX_A = (RST_CYCLES > STEP_HOLD) ? RST_CYCLES : STEP_HOLD;
   localparam int MAX_B = (STEP_GAP > LOCK_TIMEOUT) ? STEP_GAP : LOCK_TIMEOUT;
   localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TMR_W = $clog2(MAXC + 1);

   localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(STEP_HOLD - 1);
   localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(STEP_GAP - 1);
   localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_PLLRST,
      S_LOCK_WAIT,
      S_IDLE,
      S_SETUP,
      S_STEP_HI,
      S_STEP_LO,
      S_LOAD
   } state_t;

   state_t           state, state_nxt;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [CNT_W-1:0] rem, rem_nxt;
   logic             init_q, init_nxt;
   logic             done_nxt, err_nxt, accept;
   logic             ready_q, busy_q, done_q, err_q;

   assign req.req_ready = ready_q;
   assign req.busy      = busy_q;
   assign req.done      = done_q;
   assign req.err       = err_q;

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      rem_nxt   = rem;
      init_nxt  = init_q;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      accept    = 1'b0;
      case (state)
         S_PLLRST: begin
            if (tmr == RST_LAST) begin
               state_nxt = S_LOCK_WAIT;
               tmr_nxt   = '0;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         S_LOCK_WAIT: begin
            // Lock wins over a simultaneous timeout; the start-up lock is silent on success.
            if (pll_locked) begin
               state_nxt = S_IDLE;
               done_nxt  = !init_q;
               init_nxt  = 1'b0;
            end else if (tmr == LOCK_LAST) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
               init_nxt  = 1'b0;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         S_IDLE: begin
            if (req.req_valid && ready_q) begin
               accept    = 1'b1;
               tmr_nxt   = '0;
               rem_nxt   = req.req_steps;
               state_nxt = (req.req_steps == '0) ? S_LOAD : S_SETUP;
            end
         end
         S_SETUP: begin
            if (tmr == GAP_LAST) begin
               state_nxt = S_STEP_HI;
               tmr_nxt   = '0;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         S_STEP_HI: begin
            if (tmr == HOLD_LAST) begin
               state_nxt = S_STEP_LO;
               tmr_nxt   = '0;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         S_LOAD: begin
            // A load is followed by one gap, reusing the step-low path with a single remaining step.
            if (tmr == HOLD_LAST) begin
               state_nxt = S_STEP_LO;
               tmr_nxt   = '0;
               rem_nxt   = CNT_W'(1);
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         S_STEP_LO: begin
            if (tmr == GAP_LAST) begin
               tmr_nxt   = '0;
               rem_nxt   = rem - 1'b1;
               state_nxt = (rem == CNT_W'(1)) ? S_LOCK_WAIT : S_STEP_HI;
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         default: state_nxt = S_PLLRST;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n) begin
         state            <= S_PLLRST;
         tmr              <= '0;
         rem              <= '0;
         init_q           <= 1'b1;
         ready_q          <= 1'b0;
         busy_q           <= 1'b1;
         done_q           <= 1'b0;
         err_q            <= 1'b0;
         pll_reset        <= 1'b1;
         pll_phasesel     <= 2'd0;
         pll_phasedir     <= 1'b0;
         pll_phasestep    <= 1'b0;
         pll_phaseloadreg <= 1'b0;
      end else begin
         state            <= state_nxt;
         tmr              <= tmr_nxt;
         rem              <= rem_nxt;
         init_q           <= init_nxt;
         ready_q          <= (state_nxt == S_IDLE) && pll_locked;
         busy_q           <= (state_nxt != S_IDLE);
         done_q           <= done_nxt;
         err_q            <= err_nxt;
         pll_reset        <= (state_nxt == S_PLLRST);
         pll_phasestep    <= (state_nxt == S_STEP_HI);
         pll_phaseloadreg <= (state_nxt == S_LOAD);
         if (accept) begin
            pll_phasesel <= req.req_sel;
            pll_phasedir <= req.req_dir;
         end
      end
   end

`ifdef PHASE_TRACK_EN
   logic [15:0] pos [4];

   always_ff @(posedge clk_i) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) pos[i] <= '0;
      end else if (state == S_STEP_HI && state_nxt == S_STEP_LO) begin
         pos[pll_phasesel] <= pll_phasedir ? (pos[pll_phasesel] - 16'd1) : (pos[pll_phasesel] + 16'd1);
      end else if (state == S_LOAD && state_nxt == S_STEP_LO) begin
         pos[pll_phasesel] <= '0;
      end
   end

   assign phase_pos_o = {pos[3], pos[2], pos[1], pos[0]};
`endif

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed bench for ecp5pll_phase_ctrl: start-up, stepping, load, timeout, mid-run reset, back-to-back.
module tb_ecp5pll_phase_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic pll_locked = 1'b0;
   logic pll_reset, pll_phasedir, pll_phasestep, pll_phaseloadreg;
   logic [1:0] pll_phasesel;
`ifdef PHASE_TRACK_EN
   logic [63:0] phase_pos;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ecp5pll_phase_ctrl_if #(.CNT_W(8)) rq ();

   ecp5pll_phase_ctrl #(
      .RST_CYCLES(16), .STEP_HOLD(4), .STEP_GAP(4), .LOCK_TIMEOUT(10), .CNT_W(8)
   ) dut (
      .clk_i            (clk),
      .reset_n          (reset_n),
      .req              (rq),
      .pll_locked       (pll_locked),
      .pll_reset        (pll_reset),
      .pll_phasesel     (pll_phasesel),
      .pll_phasedir     (pll_phasedir),
      .pll_phasestep    (pll_phasestep),
      .pll_phaseloadreg (pll_phaseloadreg)
`ifdef PHASE_TRACK_EN
      ,
      .phase_pos_o      (phase_pos)
`endif
   );

   task automatic wait_ready();
      int n = 0;
      while (!rq.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rq.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready: req_ready=%b after %0d cycles, required 1", rq.req_ready, n);
      end
   endtask

   task automatic test_reset();
      int hi = 0, first_ready = -1, nd = 0, ne = 0;
      rq.req_valid = 1'b0; rq.req_sel = 2'd0; rq.req_dir = 1'b0; rq.req_steps = 8'd0;
      repeat (3) @(negedge clk);
      checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL rst_pll_reset: got %b required 1", pll_reset); end
      checks++; if (rq.busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b required 1", rq.busy); end
      checks++; if (rq.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", rq.req_ready); end
      checks++;
      if ({rq.done, rq.err, pll_phasestep, pll_phaseloadreg, pll_phasesel, pll_phasedir} !== 7'd0) begin
         errors++;
         $display("FAIL rst_outputs: got %b required 0000000",
                  {rq.done, rq.err, pll_phasestep, pll_phaseloadreg, pll_phasesel, pll_phasedir});
      end
      for (int i = 0; i < 40; i++) begin
         if (pll_reset) hi++;
         if (rq.req_ready && first_ready < 0) first_ready = i;
         if (rq.done) nd++;
         if (rq.err) ne++;
         if (i == 0) reset_n = 1'b1;
         if (i == 20) pll_locked = 1'b1;
         @(negedge clk);
      end
      checks++; if (hi !== 16) begin errors++; $display("FAIL startup_reset_len: got %0d required 16", hi); end
      checks++; if (first_ready !== 21) begin errors++; $display("FAIL startup_ready_cycle: got %0d required 21", first_ready); end
      checks++; if (nd !== 0 || ne !== 0) begin errors++; $display("FAIL startup_done_err: got done=%0d err=%0d required 0/0", nd, ne); end
   endtask

   task automatic test_step();
      int bad = 0, rises = 0, first_rise = -1, busy_n = 0, done_at = -1, nd = 0, ne = 0, nload = 0;
      logic prev = 1'b0;
      logic exp;
      logic [1:0] sel_s = 2'd0;
      logic dir_s = 1'b0;
      wait_ready();
      rq.req_valid = 1'b1; rq.req_sel = 2'd2; rq.req_dir = 1'b1; rq.req_steps = 8'd3;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         rq.req_valid = 1'b0;
         if (j == 1) begin sel_s = pll_phasesel; dir_s = pll_phasedir; end
         exp = (j >= 5 && j <= 28 && ((j - 5) % 8) < 4);
         if (pll_phasestep !== exp) bad++;
         if (pll_phasestep && !prev) begin rises++; if (first_rise < 0) first_rise = j; end
         prev = pll_phasestep;
         if (rq.busy) busy_n++;
         if (rq.done) begin nd++; done_at = j; end
         if (rq.err) ne++;
         if (pll_phaseloadreg) nload++;
      end
      checks++; if (sel_s !== 2'd2 || dir_s !== 1'b1) begin errors++; $display("FAIL step_sel_dir: got sel=%0d dir=%b required 2/1", sel_s, dir_s); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL step_waveform: %0d cycles differ, required 0", bad); end
      checks++; if (rises !== 3 || first_rise !== 5) begin errors++; $display("FAIL step_pulses: got %0d from cycle %0d required 3 from 5", rises, first_rise); end
      // 28 sequencing cycles plus the single LOCK_WAIT cycle
      checks++; if (busy_n !== 29) begin errors++; $display("FAIL step_busy: got %0d required 29", busy_n); end
      checks++; if (nd !== 1 || done_at !== 30) begin errors++; $display("FAIL step_done: got %0d at %0d required 1 at 30", nd, done_at); end
      checks++; if (ne !== 0 || nload !== 0) begin errors++; $display("FAIL step_spurious: got err=%0d load=%0d required 0/0", ne, nload); end
`ifdef PHASE_TRACK_EN
      checks++; if (phase_pos[32+:16] !== 16'hfffd) begin errors++; $display("FAIL step_lane2: got %h required fffd", phase_pos[32+:16]); end
`endif
   endtask

   task automatic test_back_to_back();
      int first_done = -1, last_done = -1, nd = 0;
      logic rdy14 = 1'b0, busy15 = 1'b0, rdy15 = 1'b1;
      logic [1:0] sel15 = 2'd0;
      wait_ready();
      rq.req_valid = 1'b1; rq.req_sel = 2'd1; rq.req_dir = 1'b0; rq.req_steps = 8'd1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (rq.done) begin nd++; if (first_done < 0) first_done = j; last_done = j; end
         if (j == 1) begin rq.req_sel = 2'd3; rq.req_dir = 1'b0; rq.req_steps = 8'd2; end
         if (j == 14) rdy14 = rq.req_ready;
         if (j == 15) begin busy15 = rq.busy; rdy15 = rq.req_ready; sel15 = pll_phasesel; rq.req_valid = 1'b0; end
      end
      checks++; if (first_done !== 14 || rdy14 !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got done at %0d ready=%b required 14/1", first_done, rdy14); end
      checks++; if (busy15 !== 1'b1 || rdy15 !== 1'b0 || sel15 !== 2'd3) begin errors++; $display("FAIL b2b_accept: got busy=%b ready=%b sel=%0d required 1/0/3", busy15, rdy15, sel15); end
      checks++; if (nd !== 2 || last_done !== 36) begin errors++; $display("FAIL b2b_second_done: got %0d dones last at %0d required 2 at 36", nd, last_done); end
`ifdef PHASE_TRACK_EN
      checks++; if (phase_pos[16+:16] !== 16'd1 || phase_pos[48+:16] !== 16'd2) begin errors++; $display("FAIL b2b_lanes: got lane1=%h lane3=%h required 0001/0002", phase_pos[16+:16], phase_pos[48+:16]); end
`endif
   endtask

   task automatic test_load();
      int nload = 0, first_load = -1, nstep = 0, done_at = -1;
      logic [1:0] sel_s = 2'd0;
      wait_ready();
      rq.req_valid = 1'b1; rq.req_sel = 2'd1; rq.req_dir = 1'b1; rq.req_steps = 8'd0;
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         rq.req_valid = 1'b0;
         if (j == 1) sel_s = pll_phasesel;
         if (pll_phaseloadreg) begin nload++; if (first_load < 0) first_load = j; end
         if (pll_phasestep) nstep++;
         if (rq.done && done_at < 0) done_at = j;
      end
      checks++; if (nload !== 4 || first_load !== 1) begin errors++; $display("FAIL load_pulse: got %0d from %0d required 4 from 1", nload, first_load); end
      checks++; if (nstep !== 0 || sel_s !== 2'd1) begin errors++; $display("FAIL load_nostep: got steps=%0d sel=%0d required 0/1", nstep, sel_s); end
      checks++; if (done_at !== 10) begin errors++; $display("FAIL load_done: got %0d required 10", done_at); end
`ifdef PHASE_TRACK_EN
      checks++; if (phase_pos[16+:16] !== 16'd0 || phase_pos[48+:16] !== 16'd2) begin errors++; $display("FAIL load_lanes: got lane1=%h lane3=%h required 0000/0002", phase_pos[16+:16], phase_pos[48+:16]); end
`endif
   endtask

   task automatic test_timeout();
      int busy_n = 0, err_at = -1, ne = 0, nd = 0, nrdy = 0;
      wait_ready();
      rq.req_valid = 1'b1; rq.req_sel = 2'd0; rq.req_dir = 1'b0; rq.req_steps = 8'd1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         rq.req_valid = 1'b0;
         if (j == 6) pll_locked = 1'b0;
         if (rq.busy) busy_n++;
         if (rq.err) begin ne++; err_at = j; end
         if (rq.done) nd++;
         if (rq.req_ready) nrdy++;
      end
      checks++; if (ne !== 1 || err_at !== 23) begin errors++; $display("FAIL timeout_err: got %0d at %0d required 1 at 23", ne, err_at); end
      checks++; if (busy_n !== 22 || nd !== 0) begin errors++; $display("FAIL timeout_busy: got busy=%0d done=%0d required 22/0", busy_n, nd); end
      checks++; if (nrdy !== 0) begin errors++; $display("FAIL timeout_ready_low: got %0d ready cycles required 0", nrdy); end
      pll_locked = 1'b1;
      @(negedge clk);
      checks++; if (rq.req_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready_relock: got %b required 1", rq.req_ready); end
`ifdef PHASE_TRACK_EN
      checks++; if (phase_pos[0+:16] !== 16'd1) begin errors++; $display("FAIL timeout_lane0: got %h required 0001", phase_pos[0+:16]); end
`endif
   endtask

   task automatic test_midreset();
      int hi = 0, first_ready = -1, nd = 0;
      logic step14 = 1'b0;
      logic [2:0] seldir14 = 3'd0;
      wait_ready();
      rq.req_valid = 1'b1; rq.req_sel = 2'd3; rq.req_dir = 1'b1; rq.req_steps = 8'd3;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         rq.req_valid = 1'b0;
         if (j == 14) begin step14 = pll_phasestep; seldir14 = {pll_phasesel, pll_phasedir}; end
      end
      reset_n = 1'b0;
      checks++; if (step14 !== 1'b1 || seldir14 !== 3'b111) begin errors++; $display("FAIL midrst_pre: got step=%b seldir=%b required 1/111", step14, seldir14); end
      @(negedge clk);
      checks++;
      if ({pll_reset, rq.busy, rq.req_ready, rq.done, rq.err, pll_phasestep, pll_phaseloadreg, pll_phasesel, pll_phasedir} !== 10'b11_0000_0000) begin
         errors++;
         $display("FAIL midrst_outputs: got %b required 1100000000",
                  {pll_reset, rq.busy, rq.req_ready, rq.done, rq.err, pll_phasestep, pll_phaseloadreg, pll_phasesel, pll_phasedir});
      end
`ifdef PHASE_TRACK_EN
      checks++; if (phase_pos !== 64'd0) begin errors++; $display("FAIL midrst_lanes: got %h required 0", phase_pos); end
`endif
      for (int i = 0; i < 40; i++) begin
         if (pll_reset) hi++;
         if (rq.req_ready && first_ready < 0) first_ready = i;
         if (rq.done) nd++;
         if (i == 0) reset_n = 1'b1;
         @(negedge clk);
      end
      checks++; if (hi !== 16) begin errors++; $display("FAIL midrst_reset_len: got %0d required 16", hi); end
      checks++; if (first_ready !== 17 || nd !== 0) begin errors++; $display("FAIL midrst_restart: got ready at %0d done=%0d required 17/0", first_ready, nd); end
   endtask

   initial begin
      test_reset();
      test_step();
      test_back_to_back();
      test_load();
      test_timeout();
      test_midreset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
